// File: rtl/dragon_fpga_top.sv
// DragonPHY emulation loopback: PRBS7 TX -> fixed-delay channel -> PRBS7 checker.
// All link state advances on alternate emu_clk cycles (tick = phase).
module dragon_fpga_top #(
    parameter int         CHAN_DELAY = 8,
    parameter logic [6:0] PRBS_SEED  = 7'h01,
    parameter int         ERR_LIMIT  = 4
) (
    input  logic        emu_clk,
    input  logic        rst,
    input  logic        rst_user,
    input  logic        inject_err,
    output logic [31:0] number,
    output logic [15:0] err_count,
    output logic        locked,
    output logic        tx_bit,
    output logic        rx_bit
);
    localparam int            MW       = $clog2(ERR_LIMIT + 1);
    localparam logic [MW-1:0] MISS_MAX = MW'(ERR_LIMIT);

    typedef enum logic [1:0] {IDLE, LOAD, CHECK} state_e;

    state_e                state_q, state_d;
    logic                  phase_q, phase_d;
    logic                  tick;
    logic [6:0]            tx_q, tx_d;
    logic [CHAN_DELAY-1:0] chan_q, chan_d;
    logic                  inj_q, inj_d;
    logic [6:0]            ck_q, ck_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [MW-1:0]         miss_q, miss_d;
    logic [31:0]           num_q, num_d;
    logic [15:0]           err_q, err_d;
    logic                  locked_q, locked_d;
    logic                  pred;

    assign tick      = phase_q;
    assign tx_bit    = tx_q[6];
    assign rx_bit    = chan_q[CHAN_DELAY-1] ^ inj_q;
    assign number    = num_q;
    assign err_count = err_q;
    assign locked    = locked_q;

    always_comb begin
        phase_d = ~phase_q;
        tx_d    = tx_q;
        chan_d  = chan_q;
        inj_d   = inj_q;
        if (tick) begin
            tx_d   = {tx_q[5:0], tx_q[6] ^ tx_q[5]};
            chan_d = (chan_q << 1) | CHAN_DELAY'(tx_q[6]);
            inj_d  = inject_err;
        end
    end

    // Checker always shifts in the received bit, so it resynchronizes by itself.
    always_comb begin
        state_d = state_q;
        ck_d    = ck_q;
        cnt_d   = cnt_q;
        miss_d  = miss_q;
        num_d   = num_q;
        err_d   = err_q;
        pred    = ck_q[6] ^ ck_q[5];
        if (rst_user) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            miss_d  = '0;
            num_d   = 32'd0;
            err_d   = 16'd0;
        end else if (tick) begin
            unique case (state_q)
                IDLE: begin
                    state_d = LOAD;
                    cnt_d   = 3'd0;
                end
                LOAD: begin
                    ck_d  = {ck_q[5:0], rx_bit};
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd6) begin
                        cnt_d   = 3'd0;
                        state_d = (ck_d == 7'd0) ? LOAD : CHECK;
                    end
                end
                CHECK: begin
                    ck_d = {ck_q[5:0], rx_bit};
                    if (rx_bit == pred) begin
                        num_d = num_q + 32'd1;
                    end else begin
                        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                        miss_d = miss_q + 1'b1;
                        if (miss_d == MISS_MAX) begin
                            state_d = LOAD;
                            miss_d  = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        locked_d = (state_d == CHECK);
    end

    always_ff @(posedge emu_clk or posedge rst) begin
        if (rst) begin
            phase_q  <= 1'b0;
            tx_q     <= PRBS_SEED;
            chan_q   <= '0;
            inj_q    <= 1'b0;
            state_q  <= IDLE;
            ck_q     <= 7'd0;
            cnt_q    <= 3'd0;
            miss_q   <= '0;
            num_q    <= 32'd0;
            err_q    <= 16'd0;
            locked_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            tx_q     <= tx_d;
            chan_q   <= chan_d;
            inj_q    <= inj_d;
            state_q  <= state_d;
            ck_q     <= ck_d;
            cnt_q    <= cnt_d;
            miss_q   <= miss_d;
            num_q    <= num_d;
            err_q    <= err_d;
            locked_q <= locked_d;
        end
    end
endmodule

// File: tb/tb_dragon_fpga_top.sv
// Directed bench for dragon_fpga_top: PRBS start, channel delay, lock timing,
// error injection, user hold and asynchronous reset.
`timescale 1ns/1ps
module tb_dragon_fpga_top;
    logic        emu_clk = 1'b0;
    logic        rst;
    logic        rst_user;
    logic        inject_err;
    logic [31:0] number;
    logic [15:0] err_count;
    logic        locked;
    logic        tx_bit;
    logic        rx_bit;

    int n_run;
    int n_fail;
    logic [23:0] txv;
    logic [23:0] rxv;

    dragon_fpga_top #(
        .CHAN_DELAY(8),
        .PRBS_SEED (7'h01),
        .ERR_LIMIT (4)
    ) dut (
        .emu_clk   (emu_clk),
        .rst       (rst),
        .rst_user  (rst_user),
        .inject_err(inject_err),
        .number    (number),
        .err_count (err_count),
        .locked    (locked),
        .tx_bit    (tx_bit),
        .rx_bit    (rx_bit)
    );

    always #25 emu_clk = ~emu_clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n link ticks from a tick-aligned negedge.
    task automatic tick_step(input int n);
        repeat (2 * n) @(posedge emu_clk);
        @(negedge emu_clk);
    endtask

    task automatic edge_step();
        @(posedge emu_clk);
        @(negedge emu_clk);
    endtask

    task automatic capture(output logic [23:0] tv, output logic [23:0] rv);
        for (int i = 0; i < 24; i++) begin
            tv[i] = tx_bit;
            rv[i] = rx_bit;
            tick_step(1);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_num"}, number, 32'd0);
        chk({tag, "_err"}, {16'd0, err_count}, 32'd0);
        chk({tag, "_lck"}, {31'd0, locked}, 32'd0);
        chk({tag, "_tx"}, {31'd0, tx_bit}, 32'd0);
        chk({tag, "_rx"}, {31'd0, rx_bit}, 32'd0);
    endtask

    initial begin
        n_run      = 0;
        n_fail     = 0;
        rst        = 1'b1;
        rst_user   = 1'b1;
        inject_err = 1'b0;
        repeat (60) @(negedge emu_clk);
        chk_zero("reset");

        // PRBS7 from seed 01: ones at ticks 6,12,13,18,20; rx lags by 8 ticks.
        rst = 1'b0;
        capture(txv, rxv);
        chk("tx_prbs", {8'd0, txv}, 32'h0014_3040);
        chk("rx_delay", {8'd0, rxv}, 32'h0030_4000);

        tick_step(100);
        chk("hold_num", number, 32'd0);
        chk("hold_err", {16'd0, err_count}, 32'd0);
        chk("hold_lck", {31'd0, locked}, 32'd0);

        rst_user = 1'b0;
        tick_step(7);
        chk("lock_t7_lck", {31'd0, locked}, 32'd0);
        tick_step(1);
        chk("lock_t8_lck", {31'd0, locked}, 32'd1);
        chk("lock_t8_num", number, 32'd0);
        tick_step(1);
        chk("lock_t9_num", number, 32'd1);
        tick_step(991);
        chk("run_num", number, 32'd992);
        chk("run_err", {16'd0, err_count}, 32'd0);
        chk("run_lck", {31'd0, locked}, 32'd1);

        // One flipped bit costs three predictions: its own tick, then again
        // six and seven ticks later when it sits in the feedback taps.
        inject_err = 1'b1;
        tick_step(1);
        inject_err = 1'b0;
        chk("inj_t0_num", number, 32'd993);
        tick_step(1);
        chk("inj_a_num", number, 32'd993);
        chk("inj_a_err", {16'd0, err_count}, 32'd1);
        tick_step(5);
        chk("inj_a5_num", number, 32'd998);
        tick_step(2);
        chk("inj_a7_num", number, 32'd998);
        chk("inj_a7_err", {16'd0, err_count}, 32'd3);
        chk("inj_a7_lck", {31'd0, locked}, 32'd1);
        tick_step(1);
        chk("inj_a8_num", number, 32'd999);

        rst_user = 1'b1;
        edge_step();
        rst_user = 1'b0;
        chk("usr_num", number, 32'd0);
        chk("usr_err", {16'd0, err_count}, 32'd0);
        chk("usr_lck", {31'd0, locked}, 32'd0);
        edge_step();
        tick_step(6);
        chk("usr_t7_lck", {31'd0, locked}, 32'd0);
        tick_step(1);
        chk("usr_t8_lck", {31'd0, locked}, 32'd1);
        chk("usr_t8_num", number, 32'd0);
        tick_step(1);
        chk("usr_t9_num", number, 32'd1);
        tick_step(50);
        chk("usr_run_num", number, 32'd51);

        inject_err = 1'b1;
        tick_step(1);
        chk("cont_t0_num", number, 32'd52);
        tick_step(3);
        chk("cont_a3_err", {16'd0, err_count}, 32'd3);
        chk("cont_a3_lck", {31'd0, locked}, 32'd1);
        tick_step(1);
        chk("cont_a4_err", {16'd0, err_count}, 32'd4);
        chk("cont_a4_lck", {31'd0, locked}, 32'd0);
        tick_step(6);
        chk("cont_a10_lck", {31'd0, locked}, 32'd0);
        tick_step(1);
        chk("cont_a11_lck", {31'd0, locked}, 32'd1);
        chk("cont_a11_err", {16'd0, err_count}, 32'd4);
        chk("cont_a11_num", number, 32'd52);
        inject_err = 1'b0;

        tick_step(3);
        #5;
        rst = 1'b1;
        #1;
        chk_zero("arst");
        @(negedge emu_clk);
        rst = 1'b0;
        capture(txv, rxv);
        chk("arst_tx_prbs", {8'd0, txv}, 32'h0014_3040);
        chk("arst_rx_delay", {8'd0, rxv}, 32'h0030_4000);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
